// File: rtl/video_sync_gen.sv
// Raster timing generator: pixel/line counters with horizontal and vertical FSMs, registered syncs.
// Optional macro VSG_SERRATION_EN inverts hsync on vsync lines to give a serrated composite sync.
module video_sync_gen #(
    parameter int unsigned CW       = 12,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          ce,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt,
    output logic          de,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          csync_n,
    output logic          sof
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (CW < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_param
        $error("video_sync_gen: every parameter must be >= 1");
    end
    if (CW < 32 && (H_TOTAL > (32'd1 << CW) || V_TOTAL > (32'd1 << CW))) begin : g_bad_width
        $error("video_sync_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
    end

    // Last index of each segment; an FSM leaves a segment when its counter sits here.
    localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] H_FPO_END = CW'(H_ACTIVE + H_FP - 1);
    localparam logic [CW-1:0] H_SYN_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] H_BPO_END = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] V_FPO_END = CW'(V_ACTIVE + V_FP - 1);
    localparam logic [CW-1:0] V_SYN_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] V_BPO_END = CW'(V_TOTAL - 1);

    typedef enum logic [1:0] {H_ACT, H_FPO, H_SYN, H_BPO} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FPO, V_SYN, V_BPO} v_state_t;

    h_state_t      r_h_state, w_h_state_nxt;
    v_state_t      r_v_state, w_v_state_nxt;
    logic [CW-1:0] r_h_cnt, r_v_cnt, w_h_nxt, w_v_nxt;
    logic          w_h_wrap, w_v_wrap;
    logic          r_de, r_hsync_n, r_vsync_n, r_csync_n, r_sof;
    logic          w_de_nxt, w_hsync_n_nxt, w_vsync_n_nxt, w_csync_n_nxt;

    always_comb begin
        w_h_wrap = (r_h_cnt == H_BPO_END);
        w_v_wrap = w_h_wrap && (r_v_cnt == V_BPO_END);
        w_h_nxt  = w_h_wrap ? '0 : r_h_cnt + CW'(1);
        w_v_nxt  = r_v_cnt;
        if (w_h_wrap) begin
            w_v_nxt = w_v_wrap ? '0 : r_v_cnt + CW'(1);
        end

        w_h_state_nxt = r_h_state;
        unique case (r_h_state)
            H_ACT:   if (r_h_cnt == H_ACT_END) w_h_state_nxt = H_FPO;
            H_FPO:   if (r_h_cnt == H_FPO_END) w_h_state_nxt = H_SYN;
            H_SYN:   if (r_h_cnt == H_SYN_END) w_h_state_nxt = H_BPO;
            H_BPO:   if (w_h_wrap)             w_h_state_nxt = H_ACT;
            default: w_h_state_nxt = H_BPO;
        endcase

        // The vertical FSM only moves at line wrap, so vsync spans whole lines.
        w_v_state_nxt = r_v_state;
        if (w_h_wrap) begin
            unique case (r_v_state)
                V_ACT:   if (r_v_cnt == V_ACT_END) w_v_state_nxt = V_FPO;
                V_FPO:   if (r_v_cnt == V_FPO_END) w_v_state_nxt = V_SYN;
                V_SYN:   if (r_v_cnt == V_SYN_END) w_v_state_nxt = V_BPO;
                V_BPO:   if (w_v_wrap)             w_v_state_nxt = V_ACT;
                default: w_v_state_nxt = V_BPO;
            endcase
        end

        w_de_nxt      = (w_h_state_nxt == H_ACT) && (w_v_state_nxt == V_ACT);
        w_hsync_n_nxt = (w_h_state_nxt != H_SYN);
        w_vsync_n_nxt = (w_v_state_nxt != V_SYN);
`ifdef VSG_SERRATION_EN
        w_csync_n_nxt = w_vsync_n_nxt ? w_hsync_n_nxt : ~w_hsync_n_nxt;
`else
        w_csync_n_nxt = w_hsync_n_nxt & w_vsync_n_nxt;
`endif
    end

    // Outputs are decoded from the next position so they stay aligned with the counters.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_h_cnt   <= H_BPO_END;
            r_v_cnt   <= V_BPO_END;
            r_h_state <= H_BPO;
            r_v_state <= V_BPO;
            r_de      <= 1'b0;
            r_hsync_n <= 1'b1;
            r_vsync_n <= 1'b1;
            r_csync_n <= 1'b1;
            r_sof     <= 1'b0;
        end else if (ce) begin
            r_h_cnt   <= w_h_nxt;
            r_v_cnt   <= w_v_nxt;
            r_h_state <= w_h_state_nxt;
            r_v_state <= w_v_state_nxt;
            r_de      <= w_de_nxt;
            r_hsync_n <= w_hsync_n_nxt;
            r_vsync_n <= w_vsync_n_nxt;
            r_csync_n <= w_csync_n_nxt;
            r_sof     <= w_v_wrap;
        end else begin
            r_sof     <= 1'b0;
        end
    end

    assign h_cnt   = r_h_cnt;
    assign v_cnt   = r_v_cnt;
    assign de      = r_de;
    assign hsync_n = r_hsync_n;
    assign vsync_n = r_vsync_n;
    assign csync_n = r_csync_n;
    assign sof     = r_sof;

endmodule
